shared_unit_arbiter: RTL
========================

SHARED_UNIT_ARBITER -- requirements
Module: shared_unit_arbiter

Interface
REQ-001 Parameter INPUTS, default 3, SHALL set the number of requesters sharing one pipelined unit (2..8).
REQ-002 Parameter OUTPUTS, default 3, SHALL equal INPUTS; each requester gets one result channel.
REQ-003 Parameter DATA_IN_SIZE, default 32, SHALL set the operand width per requester.
REQ-004 Parameter DATA_OUT_SIZE, default 32, SHALL set the result width per requester.
REQ-005 Parameter LATENCY, default 4, SHALL set the fixed, non-stallable latency of the shared unit (>=1).
REQ-006 Parameter CREDITS, default 2, SHALL set the per-requester result buffer depth (power of 2, >=1).
REQ-007 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-008 clk  input  1  clock; all state changes on the rising edge.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 data_in_bus  input  INPUTS*DATA_IN_SIZE  operands, {in(n-1), ..., in0}.
REQ-011 valid_in_bus  input  INPUTS  operand valid per requester.
REQ-012 ready_in_bus  output  INPUTS  operand accepted (grant) per requester.
REQ-013 data_out_bus  output  OUTPUTS*DATA_OUT_SIZE  results, {out(n-1), ..., out0}.
REQ-014 valid_out_bus  output  OUTPUTS  result valid per channel.
REQ-015 ready_out_bus  input  OUTPUTS  consumer ready per channel.
REQ-016 unit_op_data  output  DATA_IN_SIZE  operand issued to the shared unit.
REQ-017 unit_op_valid  output  1  issue strobe to the shared unit.
REQ-018 unit_res_data  input  DATA_OUT_SIZE  shared-unit result, LATENCY cycles after issue.
REQ-019 unit_res_valid  input  1  shared-unit result strobe.
REQ-020 err  output  1  sticky protocol-error flag.

Function
REQ-021 Requester i SHALL be eligible when valid_in_bus[i]=1 and credit[i]>0.
REQ-022 At most one eligible requester SHALL be granted per cycle, round-robin starting from pointer ptr; grant is combinational in the same cycle.
REQ-023 On a grant to i: ready_in_bus[i]=1, unit_op_valid=1, unit_op_data=in i; all other ready_in_bus bits SHALL be 0.
REQ-024 After a grant to i, ptr SHALL become (i+1) mod INPUTS; with no grant, ptr SHALL hold.
REQ-025 A LATENCY-stage tag pipeline SHALL carry {valid, requester id} of each issue, advancing every cycle unconditionally.
REQ-026 When the last tag stage is valid, unit_res_data SHALL be written into the result FIFO of that id on the same edge.
REQ-027 Each result FIFO SHALL be CREDITS deep and first-in first-out; its head drives data_out_bus slice i and valid_out_bus[i] = not empty.
REQ-028 credit[i] SHALL decrement on grant to i, increment on valid_out_bus[i]&ready_out_bus[i], and hold when both or neither occur; range 0..CREDITS.
REQ-029 Minimum latency: valid_in_bus[i] granted in cycle t SHALL yield valid_out_bus[i]=1 in cycle t+LATENCY+1.
REQ-030 Credit gating SHALL guarantee no FIFO overflow; a write to a full FIFO is unreachable and SHALL set err.
REQ-031 unit_res_valid differing from the last tag-stage valid in any cycle SHALL set err; the tag, not unit_res_valid, decides writes.
REQ-032 Results for one requester SHALL be returned in issue order; channels SHALL not block each other.
REQ-033 A FIFO written and read in the same cycle SHALL keep its occupancy; full FIFO read+write is legal only if occupancy was CREDITS and a read occurs.

Reset
REQ-034 On rst=1: ptr=0, all credit=CREDITS, tag pipeline invalid, FIFOs empty, valid_out_bus=0, ready_in_bus=0, unit_op_valid=0, err=0, effective immediately.
REQ-035 Reset mid-operation SHALL discard all in-flight tags and buffered results; late unit_res_valid after reset SHALL set err only if it occurs after rst deasserts.

Verification
REQ-036 INPUTS=3, LATENCY=4: valid_in_bus=3'b111 held, all ready_out=1 -> grants 0,1,2,0,... one per cycle; each out channel valid 5 cycles after its grant.
REQ-037 ready_out_bus[1]=0, valid_in_bus[1]=1 held, CREDITS=2 -> exactly 2 grants to requester 1, then ready_in_bus[1]=0; requesters 0,2 continue at full rate.
REQ-038 From REQ-037 state, pulse ready_out_bus[1] for 1 cycle -> credit[1]=1, one further grant to 1 next eligible cycle, results in issue order.
REQ-039 Only requester 2 valid, ptr=0 -> granted every cycle it has credit; ptr stays 0 after each grant (wraps from 2).
REQ-040 Inject unit_res_valid=1 with no tag in flight -> err=1 next cycle and remains 1 until rst.
REQ-041 Assert rst with 3 operands in flight -> no valid_out_bus after reset, credits read CREDITS, first new grant goes to requester 0.

Source files
------------

// File: rtl/shared_unit_arbiter.sv
// Round-robin issue of INPUTS requesters into one fixed-latency pipelined unit.
// Per-requester credits bound in-flight work to the depth of that requester's result FIFO.

module sua_lane #(
   parameter int DW      = 32,
   parameter int CREDITS = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          grant,
   input  logic          wr,
   input  logic [DW-1:0] wr_data,
   input  logic          rdy,
   output logic [DW-1:0] rd_data,
   output logic          vld,
   output logic          has_credit,
   output logic          ovf
);
   localparam int AW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
   localparam int CW = $clog2(CREDITS + 1);

   logic [DW-1:0] mem [CREDITS];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt, credit;
   logic          rd, full, wr_ok;

   assign vld        = (cnt != '0);
   assign full       = (cnt == CW'(CREDITS));
   assign rd         = vld & rdy;
   // a full FIFO may still accept a write when its head leaves on the same edge
   assign wr_ok      = wr & ~(full & ~rd);
   assign ovf        = wr & full & ~rd;
   assign rd_data    = mem[rp];
   assign has_credit = (credit != '0);

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         credit <= CW'(CREDITS);
      end else begin
         if (wr_ok) wp <= (wp == AW'(CREDITS - 1)) ? '0 : wp + 1'b1;
         if (rd)    rp <= (rp == AW'(CREDITS - 1)) ? '0 : rp + 1'b1;
         case ({wr_ok, rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         case ({grant, rd})
            2'b10:   credit <= credit - 1'b1;
            2'b01:   credit <= credit + 1'b1;
            default: credit <= credit;
         endcase
      end
   end
endmodule

module shared_unit_arbiter #(
   parameter int INPUTS        = 3,
   parameter int OUTPUTS       = 3,
   parameter int DATA_IN_SIZE  = 32,
   parameter int DATA_OUT_SIZE = 32,
   parameter int LATENCY       = 4,
   parameter int CREDITS       = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [INPUTS*DATA_IN_SIZE-1:0]    data_in_bus,
   input  logic [INPUTS-1:0]                 valid_in_bus,
   output logic [INPUTS-1:0]                 ready_in_bus,
   output logic [OUTPUTS*DATA_OUT_SIZE-1:0]  data_out_bus,
   output logic [OUTPUTS-1:0]                valid_out_bus,
   input  logic [OUTPUTS-1:0]                ready_out_bus,
   output logic [DATA_IN_SIZE-1:0]           unit_op_data,
   output logic                              unit_op_valid,
   input  logic [DATA_OUT_SIZE-1:0]          unit_res_data,
   input  logic                              unit_res_valid,
   output logic                              err
);
   localparam int IDW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

   logic [INPUTS-1:0][DATA_IN_SIZE-1:0]   din;
   logic [OUTPUTS-1:0][DATA_OUT_SIZE-1:0] dout;
   logic [INPUTS-1:0]                     elig, has_credit, lane_wr, lane_ovf, gnt;
   logic [IDW-1:0]                        ptr, gnt_id;
   logic                                  gnt_vld;
   logic [LATENCY-1:0]                    vld_pipe;
   logic [LATENCY-1:0][IDW-1:0]           id_pipe;

   assign din           = data_in_bus;
   assign data_out_bus  = dout;
   assign elig          = valid_in_bus & has_credit;

   // lowest offset from ptr wins; scanning downward lets the last hit stand
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = INPUTS - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= INPUTS) idx = idx - INPUTS;
         if (elig[IDW'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
      if (rst) gnt_vld = 1'b0;
   end

   assign gnt           = gnt_vld ? (INPUTS'(1) << gnt_id) : '0;
   assign ready_in_bus  = gnt;
   assign unit_op_valid = gnt_vld;
   assign unit_op_data  = din[gnt_id];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ptr <= '0;
      else if (gnt_vld) ptr <= (gnt_id == IDW'(INPUTS - 1)) ? '0 : gnt_id + 1'b1;
   end

   // tag pipeline mirrors the unit; it alone decides which FIFO gets a result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[0] <= gnt_vld;
         id_pipe[0]  <= gnt_id;
         for (int s = 1; s < LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            id_pipe[s]  <= id_pipe[s-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                     err <= 1'b0;
      else if ((unit_res_valid != vld_pipe[LATENCY-1]) || |lane_ovf) err <= 1'b1;
   end

   for (genvar i = 0; i < INPUTS; i++) begin : g_lane
      assign lane_wr[i] = vld_pipe[LATENCY-1] && (id_pipe[LATENCY-1] == IDW'(i));
      sua_lane #(.DW(DATA_OUT_SIZE), .CREDITS(CREDITS)) u_lane (
         .clk        (clk),
         .rst        (rst),
         .grant      (gnt[i]),
         .wr         (lane_wr[i]),
         .wr_data    (unit_res_data),
         .rdy        (ready_out_bus[i]),
         .rd_data    (dout[i]),
         .vld        (valid_out_bus[i]),
         .has_credit (has_credit[i]),
         .ovf        (lane_ovf[i])
      );
   end
endmodule
